dds_command_encoder: RTL



---
 rtl/dds_cmd_pkg.sv | 38 +++
 rtl/dds_freq_window_sel.sv | 26 ++
 rtl/dds_command_encoder.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/dds_cmd_pkg.sv
// Shared definitions for the DDS command encoder: select codes, field
// positions inside the 60-bit data payload, the frequency window table,
// the command-word layout and the encoder FSM states.
package dds_cmd_pkg;

    localparam logic [3:0] SEL_FAP_W0    = 4'h0;
    localparam logic [3:0] SEL_FREQ_FULL = 4'h1;
    localparam logic [3:0] SEL_TOFF      = 4'h4;
    localparam logic [3:0] SEL_AOFF      = 4'h5;

    localparam int AMP_LSB   = 46;
    localparam int PHASE_LSB = 32;

    // Frequency windows, searched from index 0 upwards; the first window
    // whose 32 bits cover every changed frequency bit wins.
    localparam int N_WIN = 9;
    localparam logic [N_WIN-1:0][3:0] WIN_CODE = {
        4'hF, 4'hE, 4'hD, 4'hC, 4'hB, 4'hA, 4'h9, 4'h8, 4'h0
    };
    localparam logic [N_WIN-1:0][5:0] WIN_LSB = {
        6'd0, 6'd2, 6'd4, 6'd6, 6'd8, 6'd10, 6'd12, 6'd14, 6'd16
    };

    typedef struct packed {
        logic [63:0] timestamp;
        logic [3:0]  sel;
        logic [59:0] data;
    } cmd_word_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TOFF,
        ST_AOFF,
        ST_FULL,
        ST_FAP
    } enc_state_t;

endpackage

// File: rtl/dds_freq_window_sel.sv
// Picks the narrowest-priority 32-bit frequency window that contains every
// bit that changed between the new and the shadowed frequency.
import dds_cmd_pkg::*;

module dds_freq_window_sel (
    input  logic [47:0] diff,
    output logic        hit,
    output logic [3:0]  code,
    output logic [5:0]  lsb
);

    // Walk the table from the back so the lowest matching index ends up selected.
    always_comb begin
        hit  = 1'b0;
        code = WIN_CODE[0];
        lsb  = WIN_LSB[0];
        for (int i = N_WIN - 1; i >= 0; i--) begin
            if ((diff & ~(48'hFFFF_FFFF << WIN_LSB[i])) == 48'd0) begin
                hit  = 1'b1;
                code = WIN_CODE[i];
                lsb  = WIN_LSB[i];
            end
        end
    end

endmodule

// File: rtl/dds_command_encoder.sv
// Packs one parameter-update request into the shortest run of 128-bit DDS
// command words, tracking a shadow of the controller registers.
// Handshake: a request moves on req_valid & req_ready; a word moves on
// cmd_tvalid & cmd_tready, and cmd_tdata never changes while a word waits.
import dds_cmd_pkg::*;

module dds_command_encoder #(
    parameter logic [63:0] TS_STEP        = 64'd1,
    parameter bit          SKIP_UNCHANGED = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req_valid,
    output logic          req_ready,
    input  logic [63:0]   req_timestamp,
    input  logic [4:0]    req_mask,
    input  logic [47:0]   req_freq,
    input  logic [13:0]   req_amp,
    input  logic [13:0]   req_phase,
    input  logic [13:0]   req_amp_offset,
    input  logic [59:0]   req_time_offset,
    output logic [127:0]  cmd_tdata,
    output logic          cmd_tvalid,
    input  logic          cmd_tready,
    output logic          req_done,
    output logic [2:0]    words_sent
);

    enc_state_t  state, nxt_state;

    logic [47:0] sh_freq;
    logic [13:0] sh_amp, sh_phase, sh_aoff;
    logic [59:0] sh_toff;

    logic [47:0] r_freq;
    logic [13:0] r_amp, r_phase, r_aoff;
    logic [59:0] r_toff;
    logic [63:0] r_ts;
    logic [3:0]  r_code;
    logic [5:0]  r_lsb;
    logic        p_toff, p_aoff, p_full, p_fap;
    logic [2:0]  cnt;

    logic [47:0] a_freq, diff;
    logic [13:0] a_amp, a_phase, a_aoff;
    logic [59:0] a_toff;
    logic        need_f, need_a, need_p, need_ao, need_to;
    logic        win_hit;
    logic [3:0]  win_code;
    logic [5:0]  win_lsb;

    logic        idle;
    logic [47:0] c_freq;
    logic [13:0] c_amp, c_phase, c_aoff;
    logic [59:0] c_toff;
    logic [63:0] c_ts;
    logic [3:0]  c_code;
    logic [5:0]  c_lsb;
    logic        n_toff, n_aoff, n_full, n_fap;
    cmd_word_t   w;

    dds_freq_window_sel u_win (
        .diff (diff),
        .hit  (win_hit),
        .code (win_code),
        .lsb  (win_lsb)
    );

    // Effective request values (unmasked fields fall back to the shadow) and
    // which fields actually need to travel.
    always_comb begin
        a_freq  = req_mask[0] ? req_freq        : sh_freq;
        a_amp   = req_mask[1] ? req_amp         : sh_amp;
        a_phase = req_mask[2] ? req_phase       : sh_phase;
        a_aoff  = req_mask[3] ? req_amp_offset  : sh_aoff;
        a_toff  = req_mask[4] ? req_time_offset : sh_toff;
        diff    = a_freq ^ sh_freq;
        need_f  = req_mask[0] && (!SKIP_UNCHANGED || (req_freq        != sh_freq));
        need_a  = req_mask[1] && (!SKIP_UNCHANGED || (req_amp         != sh_amp));
        need_p  = req_mask[2] && (!SKIP_UNCHANGED || (req_phase       != sh_phase));
        need_ao = req_mask[3] && (!SKIP_UNCHANGED || (req_amp_offset  != sh_aoff));
        need_to = req_mask[4] && (!SKIP_UNCHANGED || (req_time_offset != sh_toff));
    end

    // Pick the word to present next: from the incoming request when idle,
    // otherwise from the remaining pending words of the registered request.
    always_comb begin
        idle    = (state == ST_IDLE);
        c_freq  = idle ? a_freq  : r_freq;
        c_amp   = idle ? a_amp   : r_amp;
        c_phase = idle ? a_phase : r_phase;
        c_aoff  = idle ? a_aoff  : r_aoff;
        c_toff  = idle ? a_toff  : r_toff;
        c_ts    = idle ? req_timestamp : r_ts + TS_STEP;
        c_code  = idle ? (win_hit ? win_code : SEL_FAP_W0) : r_code;
        c_lsb   = idle ? (win_hit ? win_lsb  : WIN_LSB[0]) : r_lsb;
        if (idle) begin
            n_toff = need_to;
            n_aoff = need_ao;
            n_full = !win_hit;
            n_fap  = win_hit ? (need_f | need_a | need_p) : (need_a | need_p);
        end else begin
            n_toff = p_toff && (state != ST_TOFF);
            n_aoff = p_aoff && (state != ST_AOFF);
            n_full = p_full && (state != ST_FULL);
            n_fap  = p_fap  && (state != ST_FAP);
        end
        if (n_toff)      nxt_state = ST_TOFF;
        else if (n_aoff) nxt_state = ST_AOFF;
        else if (n_full) nxt_state = ST_FULL;
        else if (n_fap)  nxt_state = ST_FAP;
        else             nxt_state = ST_IDLE;
        w           = '0;
        w.timestamp = c_ts;
        case (nxt_state)
            ST_TOFF: begin
                w.sel  = SEL_TOFF;
                w.data = c_toff;
            end
            ST_AOFF: begin
                w.sel        = SEL_AOFF;
                w.data[13:0] = c_aoff;
            end
            ST_FULL: begin
                w.sel        = SEL_FREQ_FULL;
                w.data[47:0] = c_freq;
            end
            ST_FAP: begin
                w.sel                   = c_code;
                w.data[31:0]            = 32'(c_freq >> c_lsb);
                w.data[PHASE_LSB +: 14] = c_phase;
                w.data[AMP_LSB +: 14]   = c_amp;
            end
            default: w.sel = SEL_FAP_W0;
        endcase
    end

    // Encoder FSM, request registers, shadow state and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            req_ready  <= 1'b0;
            cmd_tvalid <= 1'b0;
            cmd_tdata  <= '0;
            req_done   <= 1'b0;
            words_sent <= '0;
            sh_freq    <= '0;
            sh_amp     <= '0;
            sh_phase   <= '0;
            sh_aoff    <= '0;
            sh_toff    <= '0;
            r_freq     <= '0;
            r_amp      <= '0;
            r_phase    <= '0;
            r_aoff     <= '0;
            r_toff     <= '0;
            r_ts       <= '0;
            r_code     <= '0;
            r_lsb      <= '0;
            p_toff     <= 1'b0;
            p_aoff     <= 1'b0;
            p_full     <= 1'b0;
            p_fap      <= 1'b0;
            cnt        <= '0;
        end else begin
            req_done <= 1'b0;
            if (state == ST_IDLE) begin
                req_ready <= 1'b1;
                if (req_valid && req_ready) begin
                    r_freq  <= c_freq;
                    r_amp   <= c_amp;
                    r_phase <= c_phase;
                    r_aoff  <= c_aoff;
                    r_toff  <= c_toff;
                    r_code  <= c_code;
                    r_lsb   <= c_lsb;
                    r_ts    <= c_ts;
                    p_toff  <= n_toff;
                    p_aoff  <= n_aoff;
                    p_full  <= n_full;
                    p_fap   <= n_fap;
                    cnt     <= '0;
                    if (nxt_state == ST_IDLE) begin
                        req_done   <= 1'b1;
                        words_sent <= '0;
                    end else begin
                        state      <= nxt_state;
                        req_ready  <= 1'b0;
                        cmd_tvalid <= 1'b1;
                        cmd_tdata  <= w;
                    end
                end
            end else if (cmd_tready) begin
                case (state)
                    ST_TOFF: sh_toff <= r_toff;
                    ST_AOFF: sh_aoff <= r_aoff;
                    ST_FULL: sh_freq <= r_freq;
                    ST_FAP: begin
                        sh_freq  <= r_freq;
                        sh_amp   <= r_amp;
                        sh_phase <= r_phase;
                    end
                    default: sh_toff <= sh_toff;
                endcase
                p_toff <= n_toff;
                p_aoff <= n_aoff;
                p_full <= n_full;
                p_fap  <= n_fap;
                cnt    <= cnt + 3'd1;
                state  <= nxt_state;
                if (nxt_state == ST_IDLE) begin
                    cmd_tvalid <= 1'b0;
                    req_ready  <= 1'b1;
                    req_done   <= 1'b1;
                    words_sent <= cnt + 3'd1;
                end else begin
                    cmd_tdata <= w;
                    r_ts      <= c_ts;
                end
            end
        end
    end

endmodule
